// File: rtl/alu_trojan_monitor.sv
// Compares clean vs suspect ALU outputs and probe switching activity, raising a sticky alarm.
// Optional first-mismatch capture is built when TROJAN_MON_CAPTURE_EN is defined.
module alu_trojan_monitor #(
  parameter int DATA_W          = 4,
  parameter int PROBE_W         = 8,
  parameter int CNT_W           = 16,
  parameter int WINDOW          = 64,
  parameter int MISMATCH_THRESH = 1,
  parameter int TOGGLE_THRESH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  result_ref,
  input  logic               carry_ref,
  input  logic               zero_ref,
  input  logic [DATA_W-1:0]  result_dut,
  input  logic               carry_dut,
  input  logic               zero_dut,
  input  logic [PROBE_W-1:0] ref_probe,
  input  logic [PROBE_W-1:0] dut_probe,
  output logic               alarm,
  output logic               mismatch_pulse,
  output logic               toggle_flag,
  output logic               window_done,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [DATA_W-1:0]  first_a,
  output logic [DATA_W-1:0]  first_b,
  output logic [1:0]         first_op,
  output logic               first_valid
);
  typedef enum logic [1:0] {IDLE, ARMED, ALERT} state_t;

  localparam int               WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MM_TH    = CNT_W'(MISMATCH_THRESH);
  localparam logic [CNT_W-1:0] TG_TH    = CNT_W'(TOGGLE_THRESH);

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [PROBE_W-1:0] prev_ref_q, prev_ref_d, prev_dut_q, prev_dut_d;
  logic [CNT_W-1:0]   acc_ref_q, acc_ref_d, acc_dut_q, acc_dut_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d, scnt_q, scnt_d;
  logic               alarm_q, alarm_d, mpulse_q, mpulse_d;
  logic               tflag_q, tflag_d, wdone_q, wdone_d;

  logic               proc, mm, win_last, viol;
  logic [CNT_W-1:0]   hd_ref, hd_dut, sum_ref, sum_dut, diff;

  assign proc     = in_valid & enable & ~clear & (state_q != IDLE);
  assign mm       = (result_ref != result_dut) | (carry_ref != carry_dut) | (zero_ref != zero_dut);
  assign win_last = (win_q == WIN_LAST);
  assign hd_ref   = CNT_W'($countones(ref_probe ^ prev_ref_q));
  assign hd_dut   = CNT_W'($countones(dut_probe ^ prev_dut_q));
  assign sum_ref  = acc_ref_q + hd_ref;
  assign sum_dut  = acc_dut_q + hd_dut;
  assign diff     = (sum_dut >= sum_ref) ? (sum_dut - sum_ref) : (sum_ref - sum_dut);
  assign viol     = win_last & (diff > TG_TH);

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    prev_ref_d = prev_ref_q;
    prev_dut_d = prev_dut_q;
    acc_ref_d  = acc_ref_q;
    acc_dut_d  = acc_dut_q;
    mcnt_d     = mcnt_q;
    scnt_d     = scnt_q;
    tflag_d    = tflag_q;
    mpulse_d   = 1'b0;
    wdone_d    = 1'b0;
    if (clear) begin
      state_d    = enable ? ARMED : IDLE;
      win_d      = '0;
      prev_ref_d = '0;
      prev_dut_d = '0;
      acc_ref_d  = '0;
      acc_dut_d  = '0;
      mcnt_d     = '0;
      scnt_d     = '0;
      tflag_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_d = ARMED;
        ARMED:   if (!enable) state_d = IDLE;
        ALERT:   state_d = ALERT;
        default: state_d = IDLE;
      endcase
      if (proc) begin
        mpulse_d   = mm;
        if (mm && mcnt_q != CNT_MAX) mcnt_d = mcnt_q + CNT_ONE;
        if (scnt_q != CNT_MAX) scnt_d = scnt_q + CNT_ONE;
        prev_ref_d = ref_probe;
        prev_dut_d = dut_probe;
        if (win_last) begin
          // Window verdict includes the closing sample's own activity.
          wdone_d   = 1'b1;
          win_d     = '0;
          acc_ref_d = '0;
          acc_dut_d = '0;
          if (viol) tflag_d = 1'b1;
        end else begin
          win_d     = win_q + WIN_ONE;
          acc_ref_d = sum_ref;
          acc_dut_d = sum_dut;
        end
        if (state_q == ARMED && (mcnt_d >= MM_TH || viol)) state_d = ALERT;
      end
    end
    alarm_d = (state_d == ALERT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      prev_ref_q <= '0;
      prev_dut_q <= '0;
      acc_ref_q  <= '0;
      acc_dut_q  <= '0;
      mcnt_q     <= '0;
      scnt_q     <= '0;
      alarm_q    <= 1'b0;
      mpulse_q   <= 1'b0;
      tflag_q    <= 1'b0;
      wdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      prev_ref_q <= prev_ref_d;
      prev_dut_q <= prev_dut_d;
      acc_ref_q  <= acc_ref_d;
      acc_dut_q  <= acc_dut_d;
      mcnt_q     <= mcnt_d;
      scnt_q     <= scnt_d;
      alarm_q    <= alarm_d;
      mpulse_q   <= mpulse_d;
      tflag_q    <= tflag_d;
      wdone_q    <= wdone_d;
    end
  end

  assign alarm          = alarm_q;
  assign mismatch_pulse = mpulse_q;
  assign toggle_flag    = tflag_q;
  assign window_done    = wdone_q;
  assign mismatch_cnt   = mcnt_q;
  assign sample_cnt     = scnt_q;

`ifdef TROJAN_MON_CAPTURE_EN
  logic [DATA_W-1:0] first_a_q, first_b_q;
  logic [1:0]        first_op_q;
  logic              first_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_a_q     <= '0;
      first_b_q     <= '0;
      first_op_q    <= '0;
      first_valid_q <= 1'b0;
    end else if (clear) begin
      first_a_q     <= '0;
      first_b_q     <= '0;
      first_op_q    <= '0;
      first_valid_q <= 1'b0;
    end else if (proc && mm && !first_valid_q) begin
      first_a_q     <= a;
      first_b_q     <= b;
      first_op_q    <= op;
      first_valid_q <= 1'b1;
    end
  end

  assign first_a     = first_a_q;
  assign first_b     = first_b_q;
  assign first_op    = first_op_q;
  assign first_valid = first_valid_q;
`else
  logic unused_cap;
  assign unused_cap  = ^{a, b, op};
  assign first_a     = '0;
  assign first_b     = '0;
  assign first_op    = '0;
  assign first_valid = 1'b0;
`endif
endmodule

// File: tb/tb_alu_trojan_monitor.sv
// Bench for alu_trojan_monitor: sample-level reference model checked every cycle, plus directed literal checks.
module tb_alu_trojan_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0, en2 = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [3:0] a = '0, b = '0, result_ref = '0, result_dut = '0;
  logic [1:0] op = '0;
  logic       carry_ref = 1'b0, zero_ref = 1'b0, carry_dut = 1'b0, zero_dut = 1'b0;
  logic [7:0] ref_probe = '0, dut_probe = '0;

  logic        alarm, mismatch_pulse, toggle_flag, window_done, first_valid;
  logic [15:0] mismatch_cnt, sample_cnt;
  logic [3:0]  first_a, first_b;
  logic [1:0]  first_op;

  logic       alarm2, mpulse2, tflag2, wdone2, fvalid2;
  logic [3:0] mcnt2, scnt2, fa2, fb2;
  logic [1:0] fop2;

  always #5 clk = ~clk;

  alu_trojan_monitor dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .in_valid(in_valid),
    .a(a), .b(b), .op(op), .result_ref(result_ref), .carry_ref(carry_ref), .zero_ref(zero_ref),
    .result_dut(result_dut), .carry_dut(carry_dut), .zero_dut(zero_dut),
    .ref_probe(ref_probe), .dut_probe(dut_probe),
    .alarm(alarm), .mismatch_pulse(mismatch_pulse), .toggle_flag(toggle_flag), .window_done(window_done),
    .mismatch_cnt(mismatch_cnt), .sample_cnt(sample_cnt),
    .first_a(first_a), .first_b(first_b), .first_op(first_op), .first_valid(first_valid)
  );

  alu_trojan_monitor #(.CNT_W(4), .PROBE_W(2), .WINDOW(4)) dut_small (
    .clk(clk), .rst(rst), .enable(en2), .clear(clear), .in_valid(in_valid),
    .a(a), .b(b), .op(op), .result_ref(result_ref), .carry_ref(carry_ref), .zero_ref(zero_ref),
    .result_dut(result_dut), .carry_dut(carry_dut), .zero_dut(zero_dut),
    .ref_probe(2'b00), .dut_probe(2'b00),
    .alarm(alarm2), .mismatch_pulse(mpulse2), .toggle_flag(tflag2), .window_done(wdone2),
    .mismatch_cnt(mcnt2), .sample_cnt(scnt2),
    .first_a(fa2), .first_b(fb2), .first_op(fop2), .first_valid(fvalid2)
  );

  int errs = 0, checks = 0, wd_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sample-level model: plain counters, window sums and a running/alert notion.
  bit         m_on, m_alert, m_pulse, m_wd, m_tf, m_fv;
  int         m_mc, m_sc, m_sr, m_sd, m_n;
  logic [7:0] m_pr, m_pd;
  logic [3:0] m_fa, m_fb;
  logic [1:0] m_fo;

  task automatic m_zero();
    m_alert = 0; m_pulse = 0; m_wd = 0; m_tf = 0; m_fv = 0;
    m_mc = 0; m_sc = 0; m_sr = 0; m_sd = 0; m_n = 0;
    m_pr = '0; m_pd = '0; m_fa = '0; m_fb = '0; m_fo = '0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_zero();
      m_on = 0;
    end else begin
      m_pulse = 0;
      m_wd = 0;
      if (clear) begin
        m_zero();
        m_on = enable;
      end else if (!m_on) begin
        m_on = enable;
      end else if (!enable) begin
        if (!m_alert) m_on = 0;
      end else if (in_valid) begin
        bit mm, viol;
        int d;
        viol = 0;
        mm = (result_ref != result_dut) || (carry_ref != carry_dut) || (zero_ref != zero_dut);
        if (mm) begin
          m_pulse = 1;
          if (m_mc < 65535) m_mc++;
`ifdef TROJAN_MON_CAPTURE_EN
          if (!m_fv) begin m_fv = 1; m_fa = a; m_fb = b; m_fo = op; end
`endif
        end
        if (m_sc < 65535) m_sc++;
        m_sr += $countones(ref_probe ^ m_pr);
        m_sd += $countones(dut_probe ^ m_pd);
        m_pr = ref_probe;
        m_pd = dut_probe;
        m_n++;
        if (m_n == 64) begin
          d = (m_sd > m_sr) ? m_sd - m_sr : m_sr - m_sd;
          if (d > 8) begin m_tf = 1; viol = 1; end
          m_wd = 1;
          m_n = 0; m_sr = 0; m_sd = 0;
        end
        if (m_mc >= 1 || viol) m_alert = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("alarm", alarm, m_alert);
    chk("mismatch_pulse", mismatch_pulse, m_pulse);
    chk("toggle_flag", toggle_flag, m_tf);
    chk("window_done", window_done, m_wd);
    chk("mismatch_cnt", mismatch_cnt, m_mc);
    chk("sample_cnt", sample_cnt, m_sc);
    chk("first_a", first_a, m_fa);
    chk("first_b", first_b, m_fb);
    chk("first_op", first_op, m_fo);
    chk("first_valid", first_valid, m_fv);
    if (window_done) wd_count++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic samp(input logic bad, input logic [7:0] rp, input logic [7:0] dp);
    in_valid = 1; a = 4'h3; b = 4'h5; op = 2'b00;
    result_ref = 4'h8; carry_ref = 0; zero_ref = 0;
    result_dut = bad ? 4'h9 : 4'h8; carry_dut = 0; zero_dut = 0;
    ref_probe = rp; dut_probe = dp;
    step();
  endtask

  task automatic idle();
    in_valid = 0;
    step();
  endtask

  initial begin
    rst = 1;
    repeat (3) step();
    chk("reset alarm", alarm, 0);
    chk("reset sample_cnt", sample_cnt, 0);
    chk("reset mismatch_cnt", mismatch_cnt, 0);
    rst = 0;
    step();

    // 256 matching samples, equal probes
    enable = 1; clear = 1; step(); clear = 0;
    wd_count = 0;
    for (int i = 0; i < 256; i++) samp(0, 8'(i * 37), 8'(i * 37));
    idle();
    chk("t2 mismatch_cnt", mismatch_cnt, 0);
    chk("t2 sample_cnt", sample_cnt, 256);
    chk("t2 window_done count", wd_count, 4);
    chk("t2 alarm", alarm, 0);
    chk("t2 toggle_flag", toggle_flag, 0);

    // single functional mismatch
    in_valid = 1; a = 4'hF; b = 4'hF; op = 2'b00;
    result_ref = 4'hE; carry_ref = 1; zero_ref = 0;
    result_dut = 4'h0; carry_dut = 0; zero_dut = 1;
    ref_probe = 8'h00; dut_probe = 8'h00;
    step();
    chk("t3 mismatch_pulse", mismatch_pulse, 1);
    chk("t3 mismatch_cnt", mismatch_cnt, 1);
    chk("t3 alarm", alarm, 1);
`ifdef TROJAN_MON_CAPTURE_EN
    chk("t3 first_a", first_a, 4'hF);
    chk("t3 first_b", first_b, 4'hF);
    chk("t3 first_op", first_op, 2'b00);
    chk("t3 first_valid", first_valid, 1);
`else
    chk("t3 first_valid tied", first_valid, 0);
`endif
    idle();
    chk("t3 pulse one cycle", mismatch_pulse, 0);

    // toggle-only violation over one window
    in_valid = 0; clear = 1; step(); clear = 0;
    for (int i = 0; i < 63; i++) samp(0, 8'h00, (i % 2 == 0) ? 8'hFF : 8'h00);
    chk("t4 toggle_flag before close", toggle_flag, 0);
    chk("t4 alarm before close", alarm, 0);
    samp(0, 8'h00, 8'h00);
    chk("t4 toggle_flag", toggle_flag, 1);
    chk("t4 window_done", window_done, 1);
    chk("t4 alarm", alarm, 1);
    chk("t4 mismatch_cnt", mismatch_cnt, 0);

    // clear with a simultaneous mismatching sample while in ALERT
    clear = 1; samp(1, 8'h00, 8'h00); clear = 0;
    chk("t5 mismatch_pulse", mismatch_pulse, 0);
    chk("t5 mismatch_cnt", mismatch_cnt, 0);
    chk("t5 sample_cnt", sample_cnt, 0);
    chk("t5 alarm", alarm, 0);
    chk("t5 toggle_flag", toggle_flag, 0);
    samp(1, 8'h00, 8'h00);
    chk("t5 armed processes", mismatch_pulse, 1);
    chk("t5 re-alarm", alarm, 1);
    samp(0, 8'h0F, 8'h0F);
    samp(0, 8'hF0, 8'h0F);
    chk("t1 alarm before rst", alarm, 1);

    // asynchronous reset mid-window, away from any clock edge
    #1 rst = 1;
    #1;
    chk("t1 alarm", alarm, 0);
    chk("t1 mismatch_cnt", mismatch_cnt, 0);
    chk("t1 sample_cnt", sample_cnt, 0);
    chk("t1 first_valid", first_valid, 0);
    step();
    rst = 0;
    samp(1, 8'h00, 8'h00);
    chk("t1 idle ignores sample", sample_cnt, 0);
    samp(1, 8'h00, 8'h00);
    chk("t1 armed after idle", sample_cnt, 1);

    // 4-bit counter saturation on the small instance
    in_valid = 0; en2 = 1; clear = 1; step(); clear = 0;
    for (int i = 0; i < 15; i++) samp(1, 8'h00, 8'h00);
    chk("t6 mcnt at 15", mcnt2, 15);
    for (int i = 0; i < 5; i++) samp(1, 8'h00, 8'h00);
    chk("t6 mcnt saturated", mcnt2, 15);
    chk("t6 scnt saturated", scnt2, 15);
    chk("t6 alarm", alarm2, 1);
    chk("t6 main mismatch_cnt", mismatch_cnt, 20);
    idle();
    chk("t6 alarm sticky", alarm2, 1);

    enable = 0; en2 = 0;
    repeat (2) idle();
    chk("alert holds with enable low", alarm, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_trojan_monitor.md
Name: alu_trojan_monitor

Overview:
- Runtime comparator that sits directly downstream of the paired reference (clean) and suspect ALUs.
- Consumes both registered ALU output sets plus internal-node probe taps, one sample per in_valid.
- Counts functional mismatches and accumulates per-window switching activity as a side-channel proxy.
- Raises a sticky alarm when either metric crosses its threshold.

Parameters:
DATA_W, 4, ALU operand/result width
PROBE_W, 8, width of each internal-node probe bus
CNT_W, 16, width of all counters and accumulators; PROBE_W*WINDOW must be < 2^CNT_W
WINDOW, 64, valid samples per activity window (>=2)
MISMATCH_THRESH, 1, mismatch count that triggers alarm (>=1)
TOGGLE_THRESH, 8, maximum allowed per-window |dut_toggles - ref_toggles|

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
enable  in  1  arm monitor
clear  in  1  synchronous clear of all counters, flags and capture
in_valid  in  1  current sample is valid
a  in  DATA_W  operand A applied to both ALUs
b  in  DATA_W  operand B
op  in  2  opcode
result_ref  in  DATA_W  clean ALU result
carry_ref  in  1  clean carry
zero_ref  in  1  clean zero flag
result_dut  in  DATA_W  suspect ALU result
carry_dut  in  1  suspect carry
zero_dut  in  1  suspect zero flag
ref_probe  in  PROBE_W  clean ALU internal tap
dut_probe  in  PROBE_W  suspect ALU internal tap
alarm  out  1  sticky alert
mismatch_pulse  out  1  one-cycle pulse per mismatching sample
toggle_flag  out  1  sticky: some window exceeded TOGGLE_THRESH
window_done  out  1  one-cycle pulse at each window close
mismatch_cnt  out  CNT_W  saturating mismatch count
sample_cnt  out  CNT_W  saturating processed-sample count
first_a  out  DATA_W  A of first mismatch
first_b  out  DATA_W  B of first mismatch
first_op  out  2  op of first mismatch
first_valid  out  1  capture holds data

Behaviour:
- Clock and reset: one clock clk. rst is asynchronous, active-high. Reset drives all outputs and internal registers to 0 and the state to IDLE.
- All outputs are registered.
- Sample processing: a sample is processed when in_valid=1, the state is ARMED or ALERT, enable=1 and clear=0. Effects appear after that same edge (1-cycle latency).
- Mismatch: result, carry or zero differ between ref and dut.
  - mismatch_pulse=1 for one cycle.
  - mismatch_cnt increments, saturating at all-ones.
- sample_cnt: increments per processed sample, saturating.
- Toggles:
  - hd_x = popcount(x_probe XOR prev_x) for x in {ref, dut}.
  - prev_x updates only on processed samples. prev_x resets/clears to 0.
  - Accumulators acc_ref and acc_dut add hd values.
  - win_cnt counts 0..WINDOW-1.
- Window close: on the sample with win_cnt=WINDOW-1, the window closes.
  - Compute d=|acc_dut+hd_dut - acc_ref-hd_ref|, including the current sample.
  - d>TOGGLE_THRESH sets toggle_flag.
  - window_done pulses.
  - Accumulators and win_cnt return to 0.
- FSM:
  - IDLE: samples ignored, counters hold. enable=1 moves to ARMED.
  - ARMED: processes samples.
    - Post-update mismatch_cnt>=MISMATCH_THRESH, or a toggle violation at window close, moves to ALERT on that edge.
    - enable=0 moves to IDLE.
  - ALERT: alarm=1. Keeps processing while enable=1. With enable=0 it holds in ALERT and ignores samples. Leaves only via clear or rst.
- clear: valid from any state, highest priority below rst.
  - Zeroes counters, accumulators, win_cnt, prev_x, flags and capture.
  - Next state is ARMED if enable=1, else IDLE.
  - A simultaneous in_valid sample is dropped.
- Simultaneous mismatch and window close on one sample: both are applied. A single transition to ALERT occurs.
- rst mid-window: partial window is discarded; there is no carry-over.

Optional Feature:
- Macro: TROJAN_MON_CAPTURE_EN.
- Defined: on the first mismatching processed sample since reset/clear, latch a, b and op into first_a, first_b and first_op, and set first_valid=1. Later mismatches do not overwrite the capture.
- Undefined: the capture registers are not built. first_a, first_b, first_op and first_valid are tied to 0. The port list is unchanged.

Test Plan:
1. rst=1 asserted asynchronously mid-window in ALERT -> immediately alarm=0, all counters 0, first_valid=0, state IDLE.
2. enable=1, 256 identical samples with equal probes -> mismatch_cnt=0, sample_cnt=256, window_done pulses exactly 4 times, alarm=0, toggle_flag=0.
3. Sample a=4'hF, b=4'hF, op=2'b00, ref {4'hE,c=1,z=0}, dut {4'h0,c=0,z=1} -> next edge mismatch_pulse=1, mismatch_cnt=1, alarm=1; with macro: first_a=4'hF, first_b=4'hF, first_op=2'b00, first_valid=1.
4. Outputs equal, ref_probe constant 8'h00, dut_probe alternating 8'hFF/8'h00 for 64 samples -> d=512 at sample 64, toggle_flag=1, window_done=1, alarm=1 on that edge, mismatch_cnt=0.
5. clear=1 in same cycle as a mismatching in_valid while in ALERT, enable=1 -> mismatch_pulse=0, all counters 0, alarm=0, state ARMED.
6. CNT_W=4 override, 20 consecutive mismatches -> mismatch_cnt saturates at 15, sample_cnt=15, alarm stays 1.
